// File: rtl/result_bcd_display_pkg.sv
// result_bcd_display_pkg
//   Shared definitions for the result BCD display block:
//   - active-low seven-segment constants (bit order gfedcba)
//   - converter state encoding
//   - double-dabble digit adjust helper
package result_bcd_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Standard 0-9 patterns; a segment is lit when its bit is 0.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digits of 5 or more overflow past 9 once doubled, so they are pre-biased by 3.
  function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/result_bcd_display_seg7_decode.sv
// seg7_decode
//   Converts one BCD digit into an active-low seven-segment pattern (gfedcba).
//   Ports:
//     digit_i  4-bit BCD digit
//     blank_i  force all segments off
//     dash_i   show a dash (takes priority over blank_i)
//     seg_o    7-bit active-low segment pattern
module seg7_decode
  import result_bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // Segment lookup with dash/blank overrides; non-BCD codes show blank.
  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (digit_i <= 4'd9) begin
      seg_o = SEG_DIGIT[digit_i];
    end else begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/result_bcd_display.sv
// result_bcd_display
//   Samples a two's-complement sum and overflow flag, converts the magnitude
//   to BCD with an iterative shift-add-3 engine (one bit per clock), and
//   drives active-low seven-segment digits with sign, leading-zero blanking
//   and an overflow dash display. One conversion takes N+2 clocks.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_valid     sum/ovf valid; taken only while in_ready is high
//     in_ready     block idle (combinational from state)
//     sum, ovf     adder/subtractor result and overflow flag
//     bcd          magnitude digits, digit 0 in the LSBs
//     neg, ovf_out captured sign and overflow
//     out_valid    one-cycle pulse when outputs are refreshed
//     hex          per-digit segments, active-low gfedcba, digit 0 in LSBs
//     hex_sign     minus sign digit (blank when positive or on overflow)
module result_bcd_display
  import result_bcd_display_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          sum,
  input  logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf_out,
  output logic                  out_valid,
  output logic [7*DIGITS-1:0]   hex,
  output logic [6:0]            hex_sign
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      mag_q, mag_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic              sign_q, sign_d;
  logic              ovfc_q, ovfc_d;
  logic              load_s;

  logic [BW-1:0]     scr_adj_s;
  logic [BW-1:0]     scr_shift_s;
  logic [N-1:0]      mag_shift_s;
  logic [DIGITS-1:0] blank_s;
  logic [7*DIGITS-1:0] hex_s;

  logic [BW-1:0]       bcd_q;
  logic                neg_q;
  logic                ovf_out_q;
  logic                out_valid_q;
  logic [7*DIGITS-1:0] hex_q;
  logic [6:0]          hex_sign_q;

  // Adjust-then-shift step of the double-dabble engine.
  always_comb begin
    scr_adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      scr_adj_s[4*i +: 4] = dd_adjust(scr_q[4*i +: 4]);
    end
    scr_shift_s = {scr_adj_s[BW-2:0], mag_q[N-1]};
    mag_shift_s = {mag_q[N-2:0], 1'b0};
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit are zero.
  // The decoders look at the post-shift value because outputs load on the final shift.
  always_comb begin
    logic all_zero_v;
    all_zero_v = 1'b1;
    blank_s    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero_v = all_zero_v & (scr_shift_s[4*i +: 4] == 4'd0);
      blank_s[i] = all_zero_v;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decode u_seg (
      .digit_i (scr_shift_s[4*g +: 4]),
      .blank_i (blank_s[g]),
      .dash_i  (ovfc_q),
      .seg_o   (hex_s[7*g +: 7])
    );
  end

  // Next-state logic for the converter FSM, counter and scratch registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    ovfc_d  = ovfc_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sum[N-1];
          ovfc_d  = ovf;
          // Negation wraps -2^(N-1) onto itself, which reads as 2^(N-1) unsigned.
          mag_d   = sum[N-1] ? (~sum + {{(N-1){1'b0}}, 1'b1}) : sum;
          scr_d   = '0;
          cnt_d   = CW'(N);
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        scr_d = scr_shift_s;
        mag_d = mag_shift_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          load_s  = 1'b1;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Converter state and scratch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      ovfc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      sign_q  <= sign_d;
      ovfc_q  <= ovfc_d;
    end
  end

  // Output registers: refreshed on the final shift, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      hex_q       <= {DIGITS{SEG_BLANK}};
      hex_sign_q  <= SEG_BLANK;
    end else begin
      out_valid_q <= load_s;
      if (load_s) begin
        bcd_q      <= scr_shift_s;
        neg_q      <= sign_q;
        ovf_out_q  <= ovfc_q;
        hex_q      <= hex_s;
        hex_sign_q <= (sign_q && !ovfc_q) ? SEG_DASH : SEG_BLANK;
      end else begin
        bcd_q      <= bcd_q;
        neg_q      <= neg_q;
        ovf_out_q  <= ovf_out_q;
        hex_q      <= hex_q;
        hex_sign_q <= hex_sign_q;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign ovf_out   = ovf_out_q;
  assign out_valid = out_valid_q;
  assign hex       = hex_q;
  assign hex_sign  = hex_sign_q;

endmodule
